// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - button conditioning, mode register, set-time sequencing and 1 Hz tick enable
// Optional build macro MODE_LONGPRESS_EN: long mid press jumps to mode 0, short press advances on release.
module mode_sequencer #(
  parameter int unsigned CLK_HZ           = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES  = 2500000,
  parameter int unsigned REPEAT_DELAY     = 50000000,
  parameter int unsigned REPEAT_RATE      = 10000000,
  parameter int unsigned NUM_MODES        = 4,
  parameter int unsigned LONGPRESS_CYCLES = 200000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_mid,
  input  logic       button_l,
  input  logic       button_r,
  input  logic       button_up,
  input  logic       button_down,
  output logic [3:0] mode,
  output logic       nav_l,
  output logic       nav_r,
  output logic       inc,
  output logic       dec,
  output logic       set_lock,
  output logic       load_time,
  output logic       tick_1hz
);

  localparam int NB = 5;
  localparam int BM = 0;
  localparam int BL = 1;
  localparam int BR = 2;
  localparam int BU = 3;
  localparam int BD = 4;

  localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] REP_LAST   = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] REP_RELOAD = 32'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [31:0] TICK_LAST  = 32'(CLK_HZ - 1);
  localparam logic [3:0]  MODE_LAST  = 4'(NUM_MODES - 1);

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_stable;
  logic [NB-1:0] r_stable_d;
  logic [31:0]   r_db_cnt [NB];
  logic [NB-1:0] w_rise;

  assign w_raw  = {button_down, button_up, button_r, button_l, button_mid};
  assign w_rise = r_stable & ~r_stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_stable[i] <= ~r_stable[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Hold counters count from the press-pulse cycle; reloading keeps the repeat cadence without a modulo.
  logic        w_both;
  logic        w_run_up;
  logic        w_run_dn;
  logic        w_rep_up;
  logic        w_rep_dn;
  logic [31:0] r_hold_up;
  logic [31:0] r_hold_dn;

  assign w_both   = r_stable[BU] & r_stable[BD];
  assign w_run_up = r_stable[BU] & r_stable_d[BU] & ~w_both;
  assign w_run_dn = r_stable[BD] & r_stable_d[BD] & ~w_both;
  assign w_rep_up = w_run_up && (r_hold_up == REP_LAST);
  assign w_rep_dn = w_run_dn && (r_hold_dn == REP_LAST);

  always_ff @(posedge clk) begin
    if (rst || !w_run_up)  r_hold_up <= '0;
    else if (w_rep_up)     r_hold_up <= REP_RELOAD;
    else                   r_hold_up <= r_hold_up + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || !w_run_dn)  r_hold_dn <= '0;
    else if (w_rep_dn)     r_hold_dn <= REP_RELOAD;
    else                   r_hold_dn <= r_hold_dn + 32'd1;
  end

  logic w_adv;
  logic w_jump;

`ifdef MODE_LONGPRESS_EN
  localparam logic [31:0] LP_LAST = 32'(LONGPRESS_CYCLES - 1);
  logic [31:0] r_lp_cnt;
  logic        r_lp_fired;
  logic        w_fall_mid;

  assign w_fall_mid = ~r_stable[BM] & r_stable_d[BM];
  assign w_jump     = r_stable[BM] & ~r_lp_fired & (r_lp_cnt == LP_LAST);
  // A press that already triggered the long-press jump must not also advance on release.
  assign w_adv      = w_fall_mid & ~r_lp_fired;

  always_ff @(posedge clk) begin
    if (rst || !r_stable[BM]) begin
      r_lp_cnt   <= '0;
      r_lp_fired <= 1'b0;
    end else if (w_jump) begin
      r_lp_fired <= 1'b1;
    end else if (!r_lp_fired) begin
      r_lp_cnt <= r_lp_cnt + 32'd1;
    end
  end
`else
  assign w_adv  = w_rise[BM];
  assign w_jump = 1'b0;
`endif

  logic r_l_p;
  logic r_r_p;
  logic r_up_p;
  logic r_dn_p;
  logic r_adv_p;
  logic r_jump_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_l_p    <= 1'b0;
      r_r_p    <= 1'b0;
      r_up_p   <= 1'b0;
      r_dn_p   <= 1'b0;
      r_adv_p  <= 1'b0;
      r_jump_p <= 1'b0;
    end else begin
      r_l_p    <= w_rise[BL];
      r_r_p    <= w_rise[BR];
      r_up_p   <= ~w_both & (w_rise[BU] | w_rep_up);
      r_dn_p   <= ~w_both & (w_rise[BD] | w_rep_dn);
      r_adv_p  <= w_adv;
      r_jump_p <= w_jump;
    end
  end

  logic [3:0] r_mode;
  logic [3:0] w_mode_next;
  logic       r_load;

  assign w_mode_next = (r_mode == MODE_LAST) ? 4'd0 : r_mode + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 4'd1;
      r_load <= 1'b0;
    end else begin
      r_load <= 1'b0;
      if (r_jump_p) begin
        r_mode <= 4'd0;
      end else if (r_adv_p) begin
        r_mode <= w_mode_next;
        r_load <= (r_mode == 4'd0) && (w_mode_next == 4'd1);
      end
    end
  end

  logic        w_lock;
  logic [31:0] r_pre_cnt;
  logic        r_tick;

  assign w_lock = (r_mode == 4'd0);

  // Held at 0 while editing so the first tick lands a full period after load_time.
  always_ff @(posedge clk) begin
    if (rst || w_lock) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_pre_cnt == TICK_LAST) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 32'd1;
      r_tick    <= 1'b0;
    end
  end

  logic w_mid_evt;
  assign w_mid_evt = r_adv_p | r_jump_p;

  assign mode      = r_mode;
  assign set_lock  = w_lock;
  assign load_time = r_load;
  assign nav_l     = r_l_p  & ~w_mid_evt;
  assign nav_r     = r_r_p  & ~w_mid_evt;
  assign inc       = r_up_p & ~w_mid_evt;
  assign dec       = r_dn_p & ~w_mid_evt;
  assign tick_1hz  = r_tick & ~w_lock;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - directed table and sequence checks for mode_sequencer
module tb_mode_sequencer;
  localparam int CLK_HZ = 20;
  localparam int DEB    = 4;
  localparam int RD     = 16;
  localparam int RR     = 4;
  localparam int NM     = 4;
  localparam int LP     = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_mid = 1'b0, b_l = 1'b0, b_r = 1'b0, b_up = 1'b0, b_down = 1'b0;
  logic [3:0] mode;
  logic nav_l, nav_r, inc, dec, set_lock, load_time, tick_1hz;

  mode_sequencer #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .NUM_MODES(NM), .LONGPRESS_CYCLES(LP)
  ) dut (
    .clk(clk), .rst(rst),
    .button_mid(b_mid), .button_l(b_l), .button_r(b_r),
    .button_up(b_up), .button_down(b_down),
    .mode(mode), .nav_l(nav_l), .nav_r(nav_r), .inc(inc), .dec(dec),
    .set_lock(set_lock), .load_time(load_time), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_l[$], q_r[$], q_inc[$], q_dec[$], q_load[$], q_tick[$];
  always @(negedge clk) begin
    if (nav_l)     q_l.push_back(cyc);
    if (nav_r)     q_r.push_back(cyc);
    if (inc)       q_inc.push_back(cyc);
    if (dec)       q_dec.push_back(cyc);
    if (load_time) q_load.push_back(cyc);
    if (tick_1hz)  q_tick.push_back(cyc);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [4:0] m);
    b_mid  = m[0];
    b_l    = m[1];
    b_r    = m[2];
    b_up   = m[3];
    b_down = m[4];
  endtask

  task automatic clear_q();
    q_l.delete(); q_r.delete(); q_inc.delete(); q_dec.delete();
    q_load.delete(); q_tick.delete();
  endtask

  int r_cyc;
  task automatic do_reset();
    rst = 1'b1;
    set_btn(5'b0);
    tick_n(3);
    rst = 1'b0;
    r_cyc = cyc;
    clear_q();
  endtask

  task automatic press_mid();
    b_mid = 1'b1;
    tick_n(10);
    b_mid = 1'b0;
    tick_n(20);
  endtask

  typedef struct {
    string      name;
    logic [4:0] mask;
    int         hold;
    int         e_l, e_r, e_inc, e_dec;
    int         e_lat;
    int         e_mode;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];
  int c0, c1, first, lat;
  int exp_q[$];
  int exp_load;

  initial begin
    vecs[0]  = '{"r",        5'b00100, 10, 0, 1, 0, 0,  7, 1};
    vecs[1]  = '{"l",        5'b00010, 10, 1, 0, 0, 0,  7, 1};
    vecs[2]  = '{"l_and_r",  5'b00110, 10, 1, 1, 0, 0,  7, 1};
    vecs[3]  = '{"glitch_r", 5'b00100,  3, 0, 0, 0, 0, -1, 1};
    vecs[4]  = '{"min_r",    5'b00100,  4, 0, 1, 0, 0,  7, 1};
    vecs[5]  = '{"up",       5'b01000, 10, 0, 0, 1, 0,  7, 1};
    vecs[6]  = '{"down",     5'b10000, 10, 0, 0, 0, 1,  7, 1};
    vecs[7]  = '{"up_rep",   5'b01000, 30, 0, 0, 5, 0,  7, 1};
    vecs[8]  = '{"up_down",  5'b11000, 40, 0, 0, 0, 0, -1, 1};
    vecs[9]  = '{"mid",      5'b00001, 10, 0, 0, 0, 0, -1, 2};
`ifdef MODE_LONGPRESS_EN
    vecs[10] = '{"mid_r",    5'b00101, 10, 0, 1, 0, 0,  7, 2};
`else
    vecs[10] = '{"mid_r",    5'b00101, 10, 0, 0, 0, 0, -1, 2};
`endif

    // Reset state, idle ticks
    do_reset();
    check("rst_mode", mode, 1);
    check("rst_lock", set_lock, 0);
    check("rst_pulses", {nav_l, nav_r, inc, dec, load_time, tick_1hz}, 0);
    tick_n(45);
    check("idle_tick_cnt", q_tick.size(), 2);
    if (q_tick.size() == 2) begin
      check("idle_tick0", q_tick[0], r_cyc + 20);
      check("idle_tick1", q_tick[1], r_cyc + 40);
    end
    check("idle_other", q_l.size() + q_r.size() + q_inc.size() + q_dec.size() + q_load.size(), 0);

    // Table of single-button scenarios
    for (int v = 0; v < NV; v++) begin
      do_reset();
      tick_n(2);
      c0 = cyc;
      set_btn(vecs[v].mask);
      tick_n(vecs[v].hold);
      set_btn(5'b0);
      tick_n(30);
      check({vecs[v].name, "_nav_l"}, q_l.size(),   vecs[v].e_l);
      check({vecs[v].name, "_nav_r"}, q_r.size(),   vecs[v].e_r);
      check({vecs[v].name, "_inc"},   q_inc.size(), vecs[v].e_inc);
      check({vecs[v].name, "_dec"},   q_dec.size(), vecs[v].e_dec);
      check({vecs[v].name, "_mode"},  mode,         vecs[v].e_mode);
      first = -1;
      if (q_l.size()   > 0 && (first < 0 || q_l[0]   < first)) first = q_l[0];
      if (q_r.size()   > 0 && (first < 0 || q_r[0]   < first)) first = q_r[0];
      if (q_inc.size() > 0 && (first < 0 || q_inc[0] < first)) first = q_inc[0];
      if (q_dec.size() > 0 && (first < 0 || q_dec[0] < first)) first = q_dec[0];
      lat = (first < 0) ? -1 : first - c0;
      check({vecs[v].name, "_latency"}, lat, vecs[v].e_lat);
    end

    // Glitch followed by a real press
    do_reset();
    tick_n(2);
    b_r = 1'b1; tick_n(3);
    b_r = 1'b0; tick_n(5);
    c1 = cyc;
    b_r = 1'b1; tick_n(10);
    b_r = 1'b0; tick_n(20);
    check("glitch_then_press_cnt", q_r.size(), 1);
    if (q_r.size() == 1) check("glitch_then_press_at", q_r[0], c1 + 7);

    // Mode cycling, lock, load_time and tick restart
    do_reset();
    press_mid();
    check("mode_a", mode, 2);
    press_mid();
    check("mode_b", mode, 3);
    press_mid();
    check("mode_c", mode, 0);
    check("lock_on", set_lock, 1);
    clear_q();
    tick_n(30);
    check("lock_no_tick", q_tick.size(), 0);
    check("lock_no_load", q_load.size(), 0);
    clear_q();
    c0 = cyc;
    press_mid();
    tick_n(15);
`ifdef MODE_LONGPRESS_EN
    exp_load = c0 + 18;
`else
    exp_load = c0 + 8;
`endif
    check("mode_wrap", mode, 1);
    check("lock_off", set_lock, 0);
    check("load_cnt", q_load.size(), 1);
    if (q_load.size() == 1) check("load_at", q_load[0], exp_load);
    check("tick_after_load_cnt", (q_tick.size() > 0) ? 1 : 0, 1);
    if (q_tick.size() > 0) check("tick_after_load_at", q_tick[0], exp_load + 20);

    // Long up hold: press pulse, first repeat after 16, then every 4
    do_reset();
    tick_n(2);
    c0 = cyc;
    b_up = 1'b1; tick_n(60);
    b_up = 1'b0; tick_n(20);
    exp_q.delete();
    exp_q.push_back(c0 + 7);
    for (int x = c0 + 23; x <= c0 + 66; x += 4) exp_q.push_back(x);
    check("rep60_cnt", q_inc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_inc.size(); i++)
      check($sformatf("rep60_pulse%0d", i), q_inc[i], exp_q[i]);
    check("rep60_no_dec", q_dec.size(), 0);

    // Reset in the middle of an up repeat
    do_reset();
    press_mid();
    tick_n(2);
    b_up = 1'b1;
    tick_n(25);
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    r_cyc = cyc;
    clear_q();
    check("midrst_mode", mode, 1);
    check("midrst_inc0", inc, 0);
    tick_n(1);
    check("midrst_inc1", inc, 0);
    tick_n(20);
    check("midrst_restart_cnt", (q_inc.size() > 0) ? 1 : 0, 1);
    if (q_inc.size() > 0) check("midrst_restart_at", q_inc[0], r_cyc + 7);
    b_up = 1'b0;
    tick_n(10);

`ifdef MODE_LONGPRESS_EN
    // Long press jumps to mode 0 without load; short press advances only after release debounce
    do_reset();
    press_mid();
    check("lp_start_mode", mode, 2);
    clear_q();
    b_mid = 1'b1; tick_n(40);
    b_mid = 1'b0; tick_n(20);
    check("lp_mode", mode, 0);
    check("lp_no_load", q_load.size(), 0);
    b_mid = 1'b1; tick_n(10);
    b_mid = 1'b0; tick_n(5);
    check("lp_short_before_rel", mode, 0);
    tick_n(5);
    check("lp_short_after_rel", mode, 1);
    check("lp_short_load", q_load.size(), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
